dm_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the byte-addressed data memory `dm`. It shares the single `dm` port between the CPU load/store unit (port 0) and a secondary master such as DMA or debug (port 1). It also registers every `dm` control/address/data input, checks alignment, captures read data and returns a one-cycle acknowledge. It sits between the MEM stage / DMA engine and `dm`, and is the only driver of `dm`'s `DMOp`, `DMWr`, `addr` and `din`.

---
 rtl/dm_arb_pkg.sv | 30 +++
 rtl/dm_arb_rr.sv | 24 ++
 rtl/dm_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the dm arbiter: dm op encodings, arbiter FSM states
// and the alignment rule applied to every access.
package dm_arb_pkg;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_B  = 3'b010;
    localparam logic [2:0] DM_UH = 3'b101;
    localparam logic [2:0] DM_UB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    // Byte ops and unknown encodings never fault; words need 4-byte alignment,
    // halfwords 2-byte alignment.
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lsb);
        logic mis;
        mis = 1'b0;
        case (op)
            DM_W:        mis = (lsb != 2'b00);
            DM_H, DM_UH: mis = lsb[0];
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// Combinational two-way picker: fixed priority to port 0, or round-robin
// against the port granted last.
module dm_arb_rr #(
    parameter int FIXED_PRI = 0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (FIXED_PRI != 0) begin
            gnt_id = ~req[0];
        end else if (&req) begin
            gnt_id = ~last;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter and access sequencer in front of dm: registers all dm
// inputs, checks alignment, captures load data and pulses a one-cycle ack.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [2:0]        op0,
    input  logic [2:0]        op1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [2:0]        dm_op,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout
);

    arb_state_e        state, state_nx;
    logic              port;
    logic              last;
    logic              mis;
    logic              arb_en;
    logic [1:0]        req_m;
    logic              gnt_valid;
    logic              gnt_id;
    logic              grant;
    logic              w_we;
    logic [2:0]        w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_mis;

    assign arb_en = (state == ST_IDLE) || (state == ST_DONE);

    // The port acked this cycle is hidden so its still-high req is not
    // mistaken for a fresh request.
    always_comb begin
        req_m = {req1, req0};
        if (state == ST_DONE) begin
            req_m[port] = 1'b0;
        end
        if (!arb_en) begin
            req_m = 2'b00;
        end
    end

    dm_arb_rr #(
        .FIXED_PRI(FIXED_PRI)
    ) u_rr (
        .req      (req_m),
        .last     (last),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id)
    );

    assign grant = gnt_valid;

    always_comb begin
        w_we    = we0;
        w_op    = op0;
        w_addr  = addr0;
        w_wdata = wdata0;
        if (gnt_id) begin
            w_we    = we1;
            w_op    = op1;
            w_addr  = addr1;
            w_wdata = wdata1;
        end
    end

    assign w_mis = misaligned(w_op, w_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                busy     = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                busy     = grant;
                state_nx = grant ? ST_ACCESS : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port    <= 1'b0;
            last    <= 1'b1;
            mis     <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata   <= '0;
            dm_op   <= DM_W;
            dm_wr   <= 1'b0;
            dm_addr <= '0;
            dm_din  <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (grant) begin
                port    <= gnt_id;
                last    <= gnt_id;
                mis     <= w_mis;
                dm_op   <= w_op;
                dm_addr <= w_addr;
                dm_din  <= w_wdata;
                dm_wr   <= w_we & ~w_mis;
            end
            if (state == ST_ACCESS) begin
                dm_wr <= 1'b0;
                // For an aligned access dm_wr equals the latched we, so a
                // low dm_wr here identifies a load.
                if (mis) begin
                    rdata <= '0;
                end else if (!dm_wr) begin
                    rdata <= dm_dout;
                end
                if (port) begin
                    ack1 <= 1'b1;
                    err1 <= mis;
                end else begin
                    ack0 <= 1'b1;
                    err0 <= mis;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a byte-array dm model and an ack-order
// scoreboard; a second fixed-priority instance covers FIXED_PRI = 1.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0, req1, we0, we1;
    logic [2:0]  op0, op1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1, busy, dm_wr;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [2:0]  dm_op;
    logic [8:0]  dm_addr;

    logic        f_req0, f_req1, f_we0, f_we1;
    logic [2:0]  f_op0, f_op1;
    logic [8:0]  f_addr0, f_addr1;
    logic [31:0] f_wdata0, f_wdata1;
    logic        f_ack0, f_ack1, f_err0, f_err1, f_busy, f_dm_wr;
    logic [31:0] f_rdata, f_dm_din;
    logic [31:0] f_dm_dout;
    logic [2:0]  f_dm_op;
    logic [8:0]  f_dm_addr;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rd;
    } exp_t;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] sb_rd = 32'h0;

    logic [7:0] mem [512] = '{default: 8'h00};

    dm_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRI(0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata), .busy(busy),
        .dm_op(dm_op), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    dm_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRI(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(f_req0), .req1(f_req1), .we0(f_we0), .we1(f_we1), .op0(f_op0), .op1(f_op1),
        .addr0(f_addr0), .addr1(f_addr1), .wdata0(f_wdata0), .wdata1(f_wdata1),
        .ack0(f_ack0), .ack1(f_ack1), .err0(f_err0), .err1(f_err1), .rdata(f_rdata), .busy(f_busy),
        .dm_op(f_dm_op), .dm_wr(f_dm_wr), .dm_addr(f_dm_addr), .dm_din(f_dm_din), .dm_dout(f_dm_dout)
    );

    assign f_dm_dout = 32'h0;

    // dm model: little-endian, combinational read, sign/zero extension by op
    function automatic logic [31:0] dm_fmt(input logic [2:0] op,
                                           input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        case (op)
            3'b000:  return {b3, b2, b1, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0000, b1, b0};
            3'b010:  return {{24{b0[7]}}, b0};
            3'b110:  return {24'h000000, b0};
            default: return 32'h0;
        endcase
    endfunction

    assign dm_dout = dm_fmt(dm_op, mem[dm_addr], mem[dm_addr + 9'd1],
                            mem[dm_addr + 9'd2], mem[dm_addr + 9'd3]);

    always @(posedge clk) begin
        if (dm_wr) begin
            case (dm_op)
                3'b000: begin
                    mem[dm_addr]        <= dm_din[7:0];
                    mem[dm_addr + 9'd1] <= dm_din[15:8];
                    mem[dm_addr + 9'd2] <= dm_din[23:16];
                    mem[dm_addr + 9'd3] <= dm_din[31:24];
                end
                3'b001, 3'b101: begin
                    mem[dm_addr]        <= dm_din[7:0];
                    mem[dm_addr + 9'd1] <= dm_din[15:8];
                end
                default: mem[dm_addr] <= dm_din[7:0];
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation
    always @(negedge clk) begin
        if (!rst && (ack0 || ack1)) begin
            chk("ack_onehot", 32'(ack0 & ack1), 32'h0);
            checks++;
            assert (sbq.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected_ack: got ack0=%0d ack1=%0d expected none", ack0, ack1);
            end
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("sb_port", 32'(ack1), 32'(mon_e.port));
                chk("sb_err", 32'(ack1 ? err1 : err0), 32'(mon_e.err));
                chk("sb_rdata", rdata, mon_e.rd);
            end
        end
        if (dm_wr) wr_cnt++;
    end

    // Requests must be held until their ack
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            assert (!(pend0 && !req0 && !ack0)) else begin
                failures++;
                $error("FAIL req0_hold: got req0=0 expected 1 until ack0");
            end
            assert (!(pend1 && !req1 && !ack1)) else begin
                failures++;
                $error("FAIL req1_hold: got req1=0 expected 1 until ack1");
            end
            pend0 <= ack0 ? 1'b0 : (req0 ? 1'b1 : pend0);
            pend1 <= ack1 ? 1'b0 : (req1 ? 1'b1 : pend1);
        end
    end

    task automatic push_exp(input int p, input logic we, input logic xerr, input logic [31:0] xload);
        exp_t e;
        e.port = p;
        e.err  = xerr;
        e.rd   = xerr ? 32'h0 : (we ? sb_rd : xload);
        sb_rd  = e.rd;
        sbq.push_back(e);
    endtask

    task automatic access(input int p, input logic we, input logic [2:0] op, input logic [8:0] a,
                          input logic [31:0] wd, input logic xerr, input logic [31:0] xload,
                          input string tag);
        int   n;
        logic got;
        push_exp(p, we, xerr, xload);
        @(posedge clk); #1;
        if (p == 0) begin
            req0 = 1'b1; we0 = we; op0 = op; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; op1 = op; addr1 = a; wdata1 = wd;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 2) chk({tag, "_busy"}, 32'(busy), 32'h1);
            got = (p == 0) ? ack0 : ack1;
        end
        chk({tag, "_lat"}, 32'(n), 32'd3);
        #1;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    initial begin
        int cyc, nack, last_cyc, k0, k1, nf;
        int ord [2];

        req0 = 0; req1 = 0; we0 = 0; we1 = 0; op0 = 0; op1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        f_req0 = 0; f_req1 = 0; f_we0 = 0; f_we1 = 0; f_op0 = 0; f_op1 = 0;
        f_addr0 = 0; f_addr1 = 0; f_wdata0 = 0; f_wdata1 = 0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", {ack1, ack0, err1, err0, busy, dm_wr}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_dm_op", 32'(dm_op), 32'h0);
        chk("rst_dm_addr", 32'(dm_addr), 32'h0);
        chk("rst_dm_din", dm_din, 32'h0);
        chk("fp_rst_flags", {f_ack1, f_ack0, f_err1, f_err0, f_busy, f_dm_wr}, 32'h0);
        chk("fp_rst_dm", {f_dm_op, f_dm_addr} | f_dm_din | f_rdata, 32'h0);

        access(0, 1'b1, 3'b000, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0, "st_w");
        access(0, 1'b0, 3'b000, 9'h010, 32'h0, 1'b0, 32'hDEADBEEF, "ld_w");
        access(0, 1'b1, 3'b010, 9'h005, 32'h00000080, 1'b0, 32'h0, "st_b");
        access(1, 1'b0, 3'b010, 9'h005, 32'h0, 1'b0, 32'hFFFFFF80, "ld_b");
        access(0, 1'b0, 3'b110, 9'h005, 32'h0, 1'b0, 32'h00000080, "ld_ub");
        access(0, 1'b0, 3'b001, 9'h011, 32'h0, 1'b1, 32'h0, "ld_h_mis");
        access(1, 1'b0, 3'b001, 9'h012, 32'h0, 1'b0, 32'hFFFFDEAD, "ld_h");
        access(0, 1'b0, 3'b101, 9'h012, 32'h0, 1'b0, 32'h0000DEAD, "ld_uh");
        access(1, 1'b1, 3'b000, 9'h004, 32'h0BADF00D, 1'b0, 32'h0, "st_w4");

        wr_cnt = 0;
        access(1, 1'b1, 3'b000, 9'h006, 32'hCAFEF00D, 1'b1, 32'h0, "st_w_mis");
        chk("mis_no_write", 32'(wr_cnt), 32'h0);
        access(0, 1'b0, 3'b000, 9'h004, 32'h0, 1'b0, 32'h0BADF00D, "ld_w4");

        // Simultaneous requests from idle after a port-0 grant: port 1 goes first
        push_exp(1, 1'b0, 1'b0, 32'hDEADBEEF);
        push_exp(0, 1'b0, 1'b0, 32'h0BADF00D);
        @(posedge clk); #1;
        req0 = 1; we0 = 0; op0 = 3'b000; addr0 = 9'h004;
        req1 = 1; we1 = 0; op1 = 3'b000; addr1 = 9'h010;
        nack = 0; cyc = 0;
        while (nack < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ack0) begin req0 = 0; nack++; end
            if (ack1) begin req1 = 0; nack++; end
        end
        chk("tie_idle_done", 32'(nack), 32'd2);

        // Reset during the ACCESS cycle of a store
        @(posedge clk); #1;
        req0 = 1; we0 = 1; op0 = 3'b000; addr0 = 9'h020; wdata0 = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        chk("rst_acc_dm_wr", 32'(dm_wr), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 0;
        sb_rd = 32'h0;
        @(negedge clk);
        chk("rst_acc_flags", {ack1, ack0, err1, err0, busy, dm_wr}, 32'h0);
        chk("rst_acc_rdata", rdata, 32'h0);
        chk("rst_acc_dm", {dm_op, dm_addr} | dm_din, 32'h0);
        repeat (3) @(negedge clk);
        access(0, 1'b0, 3'b000, 9'h020, 32'h0, 1'b0, 32'h12345678, "ld_rst");

        // Both ports held from reset: 0,1,0,1 with an ack every 2 cycles
        push_exp(0, 1'b0, 1'b0, 32'hDEADBEEF);
        push_exp(1, 1'b0, 1'b0, 32'h12345678);
        push_exp(0, 1'b0, 1'b0, 32'h0BADF00D);
        push_exp(1, 1'b0, 1'b0, 32'hDEADBEEF);
        @(posedge clk); #1;
        rst = 1'b1;
        req0 = 1; we0 = 0; op0 = 3'b000; addr0 = 9'h010;
        req1 = 1; we1 = 0; op1 = 3'b000; addr1 = 9'h020;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0; nack = 0; last_cyc = 0; k0 = 0; k1 = 0;
        while (nack < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack0 || ack1) begin
                if (nack == 0) chk("tie_first_lat", 32'(cyc), 32'd3);
                else chk("tie_interval", 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
                nack++;
            end
            if (ack0) begin
                k0++;
                if (k0 == 1) addr0 = 9'h004; else req0 = 0;
            end
            if (ack1) begin
                k1++;
                if (k1 == 1) addr1 = 9'h010; else req1 = 0;
            end
        end
        chk("tie_rst_done", 32'(nack), 32'd4);

        // Fixed priority: after a port-0 grant, a tie still goes to port 0
        @(posedge clk); #1;
        f_req0 = 1;
        cyc = 0;
        while (!f_ack0 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("fp_single_lat", 32'(cyc), 32'd3);
        #1 f_req0 = 0;
        @(posedge clk); #1;
        f_req0 = 1; f_req1 = 1;
        nf = 0; cyc = 0; ord[0] = 9; ord[1] = 9;
        while (nf < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (f_ack0) begin ord[nf] = 0; nf++; f_req0 = 0; end
            else if (f_ack1) begin ord[nf] = 1; nf++; f_req1 = 0; end
        end
        chk("fp_first", 32'(ord[0]), 32'd0);
        chk("fp_second", 32'(ord[1]), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
